// File: rtl/regfile_debug_dumper_pkg.sv
// Shared definitions for the register file debug dumper.
// Holds the FSM state encoding and the default frame header byte.
package regfile_debug_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_STROBE_HI = 3'd2,
    ST_STROBE_LO = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_SEND      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/regfile_debug_dumper.sv
// Walks the register file debug read port from FIRST_ADDR to LAST_ADDR and
// streams the contents as bytes: one sync byte, then 4 bytes per register,
// MSB first, over a valid/ready interface.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   start             dump request, only looked at while idle
//   busy, done        dump in progress / one-cycle completion pulse
//   dbg_addr, dbg_clk register file debug read address and read clock
//   dbg_data          register file debug read data
//   tx_data, tx_valid, tx_ready  byte stream to the sink (e.g. a UART)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// SYNC      | presenting the sync byte
// STROBE_HI | dbg_addr driven, dbg_clk high
// STROBE_LO | dbg_clk low (falling edge reads the file), data settling
// CAPTURE   | register value held in the shift register
// SEND      | presenting the 4 bytes of the current register
// DONE      | done pulse, back to IDLE
module regfile_debug_dumper
  import regfile_debug_dumper_pkg::*;
#(
  parameter int unsigned FIRST_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 31,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbg_addr,
  output logic        dbg_clk,
  input  logic [31:0] dbg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] FIRST = 5'(FIRST_ADDR);
  localparam logic [4:0] LAST  = 5'(LAST_ADDR);

  state_t      state, state_next;
  logic [4:0]  addr, addr_next;
  logic [31:0] shift, shift_next;
  logic [1:0]  byte_cnt, byte_cnt_next;
  logic [7:0]  tx_data_next;
  logic [4:0]  dbg_addr_next;
  logic        xfer;

  assign xfer = tx_valid && tx_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      addr     <= '0;
      shift    <= '0;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbg_addr <= '0;
      dbg_clk  <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_next;
      addr     <= addr_next;
      shift    <= shift_next;
      byte_cnt <= byte_cnt_next;
      // Outputs are registered copies of what the next state wants, so
      // dbg_clk in particular comes straight from a flop and cannot glitch.
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
      dbg_addr <= dbg_addr_next;
      dbg_clk  <= (state_next == ST_STROBE_HI);
      tx_data  <= tx_data_next;
      tx_valid <= (state_next == ST_SYNC) || (state_next == ST_SEND);
    end
  end

  always_comb begin
    state_next    = state;
    addr_next     = addr;
    shift_next    = shift;
    byte_cnt_next = byte_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          addr_next  = FIRST;
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (xfer) state_next = ST_STROBE_HI;
      end
      ST_STROBE_HI: state_next = ST_STROBE_LO;
      ST_STROBE_LO: begin
        // Read data is sampled on the edge that ends STROBE_LO, giving the
        // file a full clock period after the dbg_clk falling edge.
        shift_next    = dbg_data;
        byte_cnt_next = '0;
        state_next    = ST_CAPTURE;
      end
      ST_CAPTURE: state_next = ST_SEND;
      ST_SEND: begin
        if (xfer) begin
          shift_next    = {shift[23:0], 8'h00};
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            // Compare before incrementing so LAST = 31 never wraps.
            if (addr == LAST) begin
              state_next = ST_DONE;
            end else begin
              addr_next  = addr + 5'd1;
              state_next = ST_STROBE_HI;
            end
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data_next  = tx_data;
    dbg_addr_next = dbg_addr;
    if (state_next == ST_SYNC) begin
      tx_data_next = SYNC_BYTE;
    end else if (state_next == ST_SEND) begin
      tx_data_next = shift_next[31:24];
    end
    if (state_next == ST_STROBE_HI) begin
      dbg_addr_next = addr_next;
    end
  end

endmodule
